// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the single-port DataMem.
// Port 0 is the CPU load/store unit and port 1 is the secondary master (DMA/debug).
// One access is in flight at a time. Ties are round-robin unless
// DATA_MEM_ARB_FIXED_PRIO_EN is defined, in which case r0 always wins a tie.
//
// Handshake: rN_req is level-sensitive and is only sampled in IDLE. rN_gnt pulses
// for the single ACCESS cycle in which the request is driven to memory. A requester
// drops req in the cycle after gnt, or keeps it high to compete again. A read is
// answered by a one-cycle rN_rvalid pulse, with rN_rdata holding until the next one.
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_write,
    output logic [1:0]        mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // WAIT counts down from RD_LAT-1 and leaves when it reaches 1.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              cur_id_q;
    logic              cur_we_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [DATA_W-1:0] cur_wdata_q;
    logic              r0_rvalid_q, r1_rvalid_q;
    logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
    logic              load;
    logic              win_id;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: r0 wins whenever it requests.
    always_comb begin
        win_id = ~r0_req;
    end
`else
    logic last_q;

    // Round-robin: on a tie the port not granted last wins; otherwise the sole requester.
    always_comb begin
        win_id = (r0_req && r1_req) ? ~last_q : ~r0_req;
    end

    // Remember which port received the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= win_id;
        end
    end
`endif

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    load    = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cur_we_q) begin
                    state_d = S_IDLE;
                end else if (RD_LAT == 1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latency counter and the latched winning request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            cur_id_q    <= 1'b0;
            cur_we_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                cur_id_q    <= win_id;
                cur_we_q    <= win_id ? r1_we    : r0_we;
                cur_addr_q  <= win_id ? r1_addr  : r0_addr;
                cur_wdata_q <= win_id ? r1_wdata : r0_wdata;
            end
        end
    end

    // Capture read data in RESP and raise the winner's rvalid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            r0_rvalid_q <= (state_q == S_RESP) && !cur_id_q;
            r1_rvalid_q <= (state_q == S_RESP) &&  cur_id_q;
            if (state_q == S_RESP && !cur_id_q) begin
                r0_rdata_q <= mem_rdata;
            end
            if (state_q == S_RESP && cur_id_q) begin
                r1_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory strobes and grants exist only in ACCESS; address/data hold from the latch.
    always_comb begin
        r0_gnt      = (state_q == S_ACCESS) && !cur_id_q;
        r1_gnt      = (state_q == S_ACCESS) &&  cur_id_q;
        mem_write   = ((state_q == S_ACCESS) &&  cur_we_q) ? 2'b01 : 2'b00;
        mem_read    = ((state_q == S_ACCESS) && !cur_we_q) ? 2'b01 : 2'b00;
        mem_addr    = cur_addr_q;
        mem_wdata   = cur_wdata_q;
        r0_rvalid   = r0_rvalid_q;
        r1_rvalid   = r1_rvalid_q;
        r0_rdata    = r0_rdata_q;
        r1_rdata    = r1_rdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-port `DataMem` block. It lets two requesters share the one data memory: port 0 is the CPU load/store unit and port 1 is the secondary master (DMA/debug). It accepts one access at a time and drives `DataMem`'s Address/WriteData/MemWrite/MemRead. For reads, it captures ReadData and returns it to the winning requester with a one-cycle valid pulse. Arbitration is round-robin by default.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: cycles from the ACCESS cycle to `mem_rdata` being valid. Legal range is 1..3.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `r0_req`, `r1_req`  in  1  access request; held until the matching gnt.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_W  byte address.
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data.
- `r0_gnt`, `r1_gnt`  out  1  one-cycle pulse; the request has been accepted.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle pulse; rdata is valid.
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data. Holds its last value until the next rvalid.
- `mem_addr`  out  ADDR_W  to DataMem Address.
- `mem_wdata`  out  DATA_W  to DataMem WriteData.
- `mem_write`  out  2  to DataMem MemWrite: 2'b01 active, 2'b00 idle.
- `mem_read`  out  2  to DataMem MemRead: 2'b01 active, 2'b00 idle.
- `mem_rdata`  in  DATA_W  from DataMem ReadData.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: drive memory for one cycle.
  - WAIT: count RD_LAT-1 cycles (skipped when RD_LAT=1).
  - RESP: capture read data.
- IDLE with any req set → ACCESS.
  - The winner's we/addr/wdata are latched into the internal regs `cur_id`, `cur_we`, `cur_addr`, `cur_wdata`.
- ACCESS:
  - `mem_addr`/`mem_wdata` come from the latch.
  - `mem_write` = 2'b01 if `cur_we`; otherwise `mem_read` = 2'b01.
  - The winner's gnt = 1.
  - Write → IDLE. Read → WAIT, or → RESP directly when RD_LAT=1.
- WAIT: a down-counter is loaded with RD_LAT-1 on entry; at 1 → RESP.
- RESP: `mem_rdata` is registered into the winner's rdata, and rvalid pulses the following cycle. → IDLE.
- Arbitration in IDLE:
  - One requester → it wins.
  - Both → the port not granted last wins.
  - The `last` flag updates on every grant.
  - `last` resets to 1, so r0 wins the first tie.
- A requester drops req the cycle after its gnt, or holds it to request again. A held req re-competes in IDLE.
- Requests arriving while not in IDLE are ignored until IDLE; nothing is queued.
- `mem_write` and `mem_read` are never both nonzero.
- Outside ACCESS, `mem_addr`/`mem_wdata` hold their last value.

## Timing
- Reset values: state = IDLE, `last` = 1, all gnt/rvalid = 0, `mem_write` = `mem_read` = 2'b00. `mem_addr`, `mem_wdata` and all rdata reset to 0.
- Request sampled at edge T → ACCESS during cycle T+1 (gnt high in that cycle).
- Write: 2 cycles from IDLE back to IDLE. Back-to-back writes issue every 2 cycles.
- Read: rvalid is high in cycle T+2+RD_LAT. Next IDLE is in that same cycle, so rvalid and a new ACCESS never overlap.
- rvalid is combinationally independent of the req inputs.
- Reset mid-operation:
  - Asynchronous abort to reset values.
  - No rvalid is produced for the aborted read.
  - Memory strobes drop immediately.

## Configuration
- `DATA_MEM_ARB_FIXED_PRIO_EN`:
  - Defined: r0 always wins ties. The `last` flag and its logic are compiled out.
  - Undefined (default): round-robin as above.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 with both req=1.
  - Required: all gnt/rvalid = 0, `mem_write` = `mem_read` = 2'b00. After release, r0 is granted first.
- Single write then read, r0:
  - Stimulus: write 0x99999999 to addr 20, then write 0xEEEEEEEE to addr 40. Then read addr 20, then read addr 40.
  - Required: `r0_rdata` = 0x99999999, then 0xEEEEEEEE. Each rvalid lands exactly RD_LAT+2 cycles after the sampling edge.
- Tie round-robin:
  - Stimulus: both ports hold read requests for 4 grants.
  - Required: grant order r0, r1, r0, r1. The `mem_read` pulse is never overlapped.
- Fixed priority:
  - Stimulus: rebuild with `DATA_MEM_ARB_FIXED_PRIO_EN` and repeat the tie scenario.
  - Required: r0 wins every tie.
- Reset mid-read:
  - Stimulus: assert `rst_n`=0 during WAIT with RD_LAT=3.
  - Required: no rvalid; next access starts cleanly from IDLE.
- Write/read exclusion:
  - Stimulus: r0 writes 0x12345678 to addr 8 while r1 reads addr 8.
  - Required: the winner completes first. r1 reads 0x12345678 if r0 won, else the prior contents. `mem_write` and `mem_read` are never simultaneously 2'b01.
